div_share_arb: RTL
==================

DIV_SHARE_ARB -- requirements
Module: div_share_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters sharing one divider (2..8).
REQ-002 SHALL have parameter DEPTH, default 8, tag FIFO depth; it bounds the divisions in flight (power of 2, at least DIV_LAT+1).
REQ-003 SHALL have parameter DIV_LAT, default 7, number of post-reset cycles during which the divider result path is not trusted.
REQ-004 SHALL have port clk, input, 1 bit, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, NREQ bits, per-requester request strobe.
REQ-007 SHALL have port req_ready, output, NREQ bits, per-requester accept.
REQ-008 SHALL have port req_n, input, NREQ*48 bits, signed numerators; requester i uses bits [48i+47:48i].
REQ-009 SHALL have port req_d, input, NREQ*48 bits, signed denominators, packed like req_n.
REQ-010 SHALL have port div_sync_in, output, 1 bit, divider input strobe.
REQ-011 SHALL have port div_n, output, 48 bits, signed divider numerator.
REQ-012 SHALL have port div_d, output, 48 bits, signed divider denominator.
REQ-013 SHALL have port div_sync_out, input, 1 bit, divider result strobe; one pulse per result.
REQ-014 SHALL have port div_q, input, 18 bits, signed quotient; valid while div_sync_out=1.
REQ-015 SHALL have port rsp_valid, output, NREQ bits, one-hot result strobe.
REQ-016 SHALL have port rsp_q, output, 18 bits, signed quotient for the flagged requester.
REQ-017 SHALL have port busy, output, 1 bit, high while any division is in flight.
REQ-018 SHALL have port err, output, 1 bit, sticky protocol-error flag.

Function
REQ-019 SHALL arbitrate round-robin: pointer ptr; grant = first i with req_valid[i]=1, scanning from ptr upward mod NREQ.
REQ-020 SHALL drive req_ready combinationally: only the granted bit may be high, and only when count<DEPTH and drain=0.
REQ-021 SHALL treat req_valid[i]&req_ready[i] as the issue event, at most one issue per cycle; on issue, ptr <= granted+1 mod NREQ; otherwise ptr holds.
REQ-022 SHALL register each issue: cycle t issue -> at t+1, div_sync_in=1 and div_n/div_d = the granted requester's operands; at t+1 without an issue, div_sync_in=0 and div_n/div_d hold their last values.
REQ-023 SHALL push the granted index into the tag FIFO on issue.
REQ-024 SHALL pop the FIFO head tag on each div_sync_out=1 with count>0; the next cycle rsp_valid has only bit [tag] set and rsp_q=div_q. rsp_valid=0 in all other cycles, and rsp_q holds.
REQ-025 SHALL support a push and a pop in the same cycle with count unchanged; a push is still refused when count=DEPTH, even if a pop occurs that cycle.
REQ-026 SHALL, on div_sync_out=1 with count=0 and drain=0, set err=1, pop nothing and emit no rsp_valid; err clears only on reset.
REQ-027 SHALL have no response backpressure; requesters must sink rsp_valid every cycle.
REQ-028 SHALL pass operands unchanged, with no width change; divide-by-zero is the divider's concern.
REQ-029 SHALL drive busy = (count!=0) | div_sync_in.
REQ-030 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-031 SHALL, while rst=0, asynchronously force: ptr=0, count=0, FIFO pointers=0, div_sync_in=0, div_n=0, div_d=0, rsp_valid=0, rsp_q=0, err=0; req_ready=0 and busy=0 follow.
REQ-032 SHALL load drain=DIV_LAT on reset; after release drain decrements by 1 per cycle to 0.
REQ-033 SHALL, while drain!=0, hold req_ready=0 and silently ignore div_sync_out (no err, no rsp); this flushes results of divisions in flight when reset asserts mid-operation.

Verification
REQ-034 Single request: after drain, req_valid=001, N=1000, D=10 -> req_ready[0] same cycle; div_sync_in one cycle later with div_n=1000, div_d=10; divider returns 100 -> next cycle rsp_valid=001, rsp_q=100, then busy=0.
REQ-035 Fairness: all three req_valid held high for 6 cycles -> grant order 0,1,2,0,1,2; each returned quotient is tagged to the matching requester in issue order.
REQ-036 Full: divider stalled, 9 back-to-back requests -> exactly 8 accepted, req_ready=0 at count=8; one result plus a new request in the same cycle -> request refused, count stays 8.
REQ-037 Spurious result: div_sync_out=1 with count=0 after drain -> err=1 and stays 1; rsp_valid stays 0.
REQ-038 Mid-flight reset: 3 in flight, pulse rst low, divider emits 3 late results within DIV_LAT cycles -> no rsp_valid, err=0, count=0.
REQ-039 Reset values: assert rst asynchronously between clock edges -> all outputs reach their REQ-031 values before the next edge.

Source files
------------

// File: rtl/div_share_arb.sv
// Shares one pipelined divider among NREQ requesters: round-robin issue,
// tag FIFO to route each quotient back, post-reset drain of stale results.
module div_share_arb #(
   parameter int NREQ    = 3,
   parameter int DEPTH   = 8,
   parameter int DIV_LAT = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*48-1:0]       req_n,
   input  logic [NREQ*48-1:0]       req_d,
   output logic                     div_sync_in,
   output logic signed [47:0]       div_n,
   output logic signed [47:0]       div_d,
   input  logic                     div_sync_out,
   input  logic signed [17:0]       div_q,
   output logic [NREQ-1:0]          rsp_valid,
   output logic signed [17:0]       rsp_q,
   output logic                     busy,
   output logic                     err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = (DIV_LAT > 0) ? $clog2(DIV_LAT + 1) : 1;

   logic [IW-1:0]         ptr;
   logic [IW-1:0]         gnt_idx_p0;
   logic                  gnt_found_p0;
   logic                  can_accept;
   logic                  issue_p0;
   logic                  drained;
   logic                  pop;
   logic                  spurious;
   logic [CW-1:0]         count;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [DW-1:0]         drain;
   logic [IW-1:0]         head_tag;
   logic [NREQ-1:0]       rsp_onehot;
   logic signed [47:0]    sel_n_p0;
   logic signed [47:0]    sel_d_p0;
   logic [IW-1:0]         tag_mem [DEPTH];

   // Requester index base+off, wrapped modulo NREQ.
   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return IW'(s);
   endfunction

   // ---- stage p0: round-robin grant and operand select ----
   always_comb begin
      gnt_found_p0 = 1'b0;
      gnt_idx_p0   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found_p0 && req_valid[rr_idx(ptr, k)]) begin
            gnt_found_p0 = 1'b1;
            gnt_idx_p0   = rr_idx(ptr, k);
         end
      end
   end

   always_comb begin
      sel_n_p0 = '0;
      sel_d_p0 = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (IW'(k) == gnt_idx_p0) begin
            sel_n_p0 = req_n[k*48 +: 48];
            sel_d_p0 = req_d[k*48 +: 48];
         end
      end
   end

   assign drained    = (drain == '0);
   // A pop in the same cycle does not free a slot for this cycle's request.
   assign can_accept = (count < CW'(DEPTH)) && drained;
   assign issue_p0   = gnt_found_p0 && can_accept;

   always_comb begin
      req_ready = '0;
      if (issue_p0) req_ready[gnt_idx_p0] = 1'b1;
   end

   assign pop      = div_sync_out && (count != '0) && drained;
   assign spurious = div_sync_out && (count == '0) && drained;
   assign head_tag = tag_mem[rd_ptr];

   always_comb begin
      rsp_onehot = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (IW'(k) == head_tag) rsp_onehot[k] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr    <= '0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         drain  <= DW'(DIV_LAT);
         err    <= 1'b0;
      end else begin
         if (!drained) drain <= drain - 1'b1;
         if (issue_p0) begin
            ptr    <= rr_idx(gnt_idx_p0, 1);
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({issue_p0, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (spurious) err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (issue_p0) tag_mem[wr_ptr] <= gnt_idx_p0;
   end

   // ---- stage p1: registered divider issue ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_sync_in <= 1'b0;
         div_n       <= '0;
         div_d       <= '0;
      end else begin
         div_sync_in <= issue_p0;
         if (issue_p0) begin
            div_n <= sel_n_p0;
            div_d <= sel_d_p0;
         end
      end
   end

   // ---- response stage: tagged quotient back to its requester ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= '0;
         rsp_q     <= '0;
      end else begin
         rsp_valid <= pop ? rsp_onehot : '0;
         if (pop) rsp_q <= div_q;
      end
   end

   assign busy = (count != '0) | div_sync_in;

endmodule
